// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared core constants, ALU opcode enum and EX control struct
package core_pkg;

    localparam int DATA_WIDTH     = 32;
    localparam int OPCODE_LENGTH  = 4;
    localparam int REG_ADDR_WIDTH = 5;

    typedef enum logic [OPCODE_LENGTH-1:0] {
        AND = 4'd0,
        OR  = 4'd1,
        ADD = 4'd2,
        XOR = 4'd3,
        SUB = 4'd4,
        SLT = 4'd5,
        SLL = 4'd6,
        SRL = 4'd7,
        EQ  = 4'd8,
        SRA = 4'd9,
        BGE = 4'd10,
        BNE = 4'd12
    } alu_op_t;

    typedef struct packed {
        logic regwrite;
        logic memread;
        logic memwrite;
        logic branch;
        logic alusrc;
    } ex_ctrl_t;

endpackage

// File: rtl/fwd_mux.sv
// rtl/fwd_mux.sv - single-operand forwarding select, EX/MEM over MEM/WB, never x0
module fwd_mux #(
    parameter int DATA_WIDTH     = core_pkg::DATA_WIDTH,
    parameter int REG_ADDR_WIDTH = core_pkg::REG_ADDR_WIDTH
) (
    input  logic [REG_ADDR_WIDTH-1:0] rs_i,
    input  logic [DATA_WIDTH-1:0]     rf_data_i,
    input  logic [REG_ADDR_WIDTH-1:0] exmem_rd_i,
    input  logic                      exmem_regwrite_i,
    input  logic [DATA_WIDTH-1:0]     exmem_result_i,
    input  logic [REG_ADDR_WIDTH-1:0] memwb_rd_i,
    input  logic                      memwb_regwrite_i,
    input  logic [DATA_WIDTH-1:0]     memwb_result_i,
    output logic [DATA_WIDTH-1:0]     data_o
);

    // Youngest producer wins; a write to x0 never forwards.
    always_comb begin
        data_o = rf_data_i;
        if (exmem_regwrite_i && (exmem_rd_i != '0) && (exmem_rd_i == rs_i)) begin
            data_o = exmem_result_i;
        end else if (memwb_regwrite_i && (memwb_rd_i != '0) && (memwb_rd_i == rs_i)) begin
            data_o = memwb_result_i;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with forwarding and load-use bubbles (optional ID_EX_PERF_CNT_EN)
module id_ex_stage
    import core_pkg::*;
#(
    parameter int DATA_WIDTH     = core_pkg::DATA_WIDTH,
    parameter int OPCODE_LENGTH  = core_pkg::OPCODE_LENGTH,
    parameter int REG_ADDR_WIDTH = core_pkg::REG_ADDR_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      id_valid_i,
    input  logic [DATA_WIDTH-1:0]     id_pc_i,
    input  logic [DATA_WIDTH-1:0]     id_rs1_data_i,
    input  logic [DATA_WIDTH-1:0]     id_rs2_data_i,
    input  logic [DATA_WIDTH-1:0]     id_imm_i,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1_i,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2_i,
    input  logic [REG_ADDR_WIDTH-1:0] id_rd_i,
    input  logic                      id_alusrc_i,
    input  logic [OPCODE_LENGTH-1:0]  id_operation_i,
    input  logic                      id_regwrite_i,
    input  logic                      id_memread_i,
    input  logic                      id_memwrite_i,
    input  logic                      id_branch_i,
    input  logic                      stall_i,
    input  logic                      flush_i,
    input  logic [REG_ADDR_WIDTH-1:0] exmem_rd_i,
    input  logic                      exmem_regwrite_i,
    input  logic [DATA_WIDTH-1:0]     exmem_result_i,
    input  logic [REG_ADDR_WIDTH-1:0] memwb_rd_i,
    input  logic                      memwb_regwrite_i,
    input  logic [DATA_WIDTH-1:0]     memwb_result_i,
    output logic [DATA_WIDTH-1:0]     SrcA,
    output logic [DATA_WIDTH-1:0]     SrcB,
    output logic [OPCODE_LENGTH-1:0]  Operation,
    output logic                      ex_valid_o,
    output logic                      ex_regwrite_o,
    output logic                      ex_memread_o,
    output logic                      ex_memwrite_o,
    output logic                      ex_branch_o,
    output logic [REG_ADDR_WIDTH-1:0] ex_rd_o,
    output logic [DATA_WIDTH-1:0]     ex_pc_o,
    output logic [DATA_WIDTH-1:0]     ex_store_data_o,
    output logic                      load_use_stall_o
`ifdef ID_EX_PERF_CNT_EN
    ,
    output logic [31:0]               bubble_cnt_o,
    output logic [31:0]               stall_cnt_o
`endif
);

    logic                      valid_d, valid_q;
    ex_ctrl_t                  ctrl_d, ctrl_q;
    logic [OPCODE_LENGTH-1:0]  op_d, op_q;
    logic [REG_ADDR_WIDTH-1:0] rd_d, rd_q;
    logic [REG_ADDR_WIDTH-1:0] rs1_d, rs1_q;
    logic [REG_ADDR_WIDTH-1:0] rs2_d, rs2_q;
    logic [DATA_WIDTH-1:0]     pc_d, pc_q;
    logic [DATA_WIDTH-1:0]     rs1_data_d, rs1_data_q;
    logic [DATA_WIDTH-1:0]     rs2_data_d, rs2_data_q;
    logic [DATA_WIDTH-1:0]     imm_d, imm_q;
    logic                      load_use;
    logic [DATA_WIDTH-1:0]     fwd_rs1, fwd_rs2;

    // A load in EX whose rd feeds the instruction waiting in ID cannot be forwarded in time.
    always_comb begin
        load_use = valid_q && ctrl_q.memread && (rd_q != '0) && id_valid_i &&
                   ((id_rs1_i == rd_q) || (id_rs2_i == rd_q));
    end

    assign load_use_stall_o = load_use & ~flush_i;

    // Next state: flush bubble > stall hold > load-use bubble > capture ID.
    always_comb begin
        valid_d    = valid_q;
        ctrl_d     = ctrl_q;
        op_d       = op_q;
        rd_d       = rd_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        pc_d       = pc_q;
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        imm_d      = imm_q;
        if (flush_i || (!stall_i && load_use)) begin
            valid_d    = 1'b0;
            ctrl_d     = '0;
            op_d       = '0;
            rd_d       = '0;
            rs1_d      = '0;
            rs2_d      = '0;
            pc_d       = '0;
            rs1_data_d = '0;
            rs2_data_d = '0;
            imm_d      = '0;
        end else if (!stall_i) begin
            valid_d         = id_valid_i;
            ctrl_d.regwrite = id_regwrite_i & id_valid_i;
            ctrl_d.memread  = id_memread_i & id_valid_i;
            ctrl_d.memwrite = id_memwrite_i & id_valid_i;
            ctrl_d.branch   = id_branch_i & id_valid_i;
            ctrl_d.alusrc   = id_alusrc_i;
            op_d            = id_operation_i;
            rd_d            = id_rd_i;
            rs1_d           = id_rs1_i;
            rs2_d           = id_rs2_i;
            pc_d            = id_pc_i;
            rs1_data_d      = id_rs1_data_i;
            rs2_data_d      = id_rs2_data_i;
            imm_d           = id_imm_i;
        end
    end

    // Pipeline register with synchronous clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            ctrl_q     <= '0;
            op_q       <= '0;
            rd_q       <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            pc_q       <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
        end else begin
            valid_q    <= valid_d;
            ctrl_q     <= ctrl_d;
            op_q       <= op_d;
            rd_q       <= rd_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            pc_q       <= pc_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            imm_q      <= imm_d;
        end
    end

    fwd_mux #(
        .DATA_WIDTH     (DATA_WIDTH),
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
    ) u_fwd_rs1 (
        .rs_i             (rs1_q),
        .rf_data_i        (rs1_data_q),
        .exmem_rd_i       (exmem_rd_i),
        .exmem_regwrite_i (exmem_regwrite_i),
        .exmem_result_i   (exmem_result_i),
        .memwb_rd_i       (memwb_rd_i),
        .memwb_regwrite_i (memwb_regwrite_i),
        .memwb_result_i   (memwb_result_i),
        .data_o           (fwd_rs1)
    );

    fwd_mux #(
        .DATA_WIDTH     (DATA_WIDTH),
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
    ) u_fwd_rs2 (
        .rs_i             (rs2_q),
        .rf_data_i        (rs2_data_q),
        .exmem_rd_i       (exmem_rd_i),
        .exmem_regwrite_i (exmem_regwrite_i),
        .exmem_result_i   (exmem_result_i),
        .memwb_rd_i       (memwb_rd_i),
        .memwb_regwrite_i (memwb_regwrite_i),
        .memwb_result_i   (memwb_result_i),
        .data_o           (fwd_rs2)
    );

    assign SrcA            = fwd_rs1;
    assign SrcB            = ctrl_q.alusrc ? imm_q : fwd_rs2;
    assign ex_store_data_o = fwd_rs2;
    assign Operation       = op_q;
    assign ex_valid_o      = valid_q;
    assign ex_regwrite_o   = ctrl_q.regwrite;
    assign ex_memread_o    = ctrl_q.memread;
    assign ex_memwrite_o   = ctrl_q.memwrite;
    assign ex_branch_o     = ctrl_q.branch;
    assign ex_rd_o         = rd_q;
    assign ex_pc_o         = pc_q;

`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] bubble_cnt_q, stall_cnt_q;

    // Count inserted bubbles and held cycles, using the same priority as the register update.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bubble_cnt_q <= '0;
            stall_cnt_q  <= '0;
        end else begin
            if (flush_i || (!stall_i && load_use)) begin
                bubble_cnt_q <= bubble_cnt_q + 32'd1;
            end
            if (!flush_i && stall_i) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign bubble_cnt_o = bubble_cnt_q;
    assign stall_cnt_o  = stall_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - self-checking bench for id_ex_stage
module tb_id_ex_stage;
    import core_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid_i;
    logic [31:0] id_pc_i, id_rs1_data_i, id_rs2_data_i, id_imm_i;
    logic [4:0]  id_rs1_i, id_rs2_i, id_rd_i;
    logic        id_alusrc_i;
    logic [3:0]  id_operation_i;
    logic        id_regwrite_i, id_memread_i, id_memwrite_i, id_branch_i;
    logic        stall_i, flush_i;
    logic [4:0]  exmem_rd_i, memwb_rd_i;
    logic        exmem_regwrite_i, memwb_regwrite_i;
    logic [31:0] exmem_result_i, memwb_result_i;
    logic [31:0] SrcA, SrcB, ex_pc_o, ex_store_data_o;
    logic [3:0]  Operation;
    logic        ex_valid_o, ex_regwrite_o, ex_memread_o, ex_memwrite_o, ex_branch_o;
    logic [4:0]  ex_rd_o;
    logic        load_use_stall_o;
`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] bubble_cnt_o, stall_cnt_o;
`endif

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .id_valid_i       (id_valid_i),
        .id_pc_i          (id_pc_i),
        .id_rs1_data_i    (id_rs1_data_i),
        .id_rs2_data_i    (id_rs2_data_i),
        .id_imm_i         (id_imm_i),
        .id_rs1_i         (id_rs1_i),
        .id_rs2_i         (id_rs2_i),
        .id_rd_i          (id_rd_i),
        .id_alusrc_i      (id_alusrc_i),
        .id_operation_i   (id_operation_i),
        .id_regwrite_i    (id_regwrite_i),
        .id_memread_i     (id_memread_i),
        .id_memwrite_i    (id_memwrite_i),
        .id_branch_i      (id_branch_i),
        .stall_i          (stall_i),
        .flush_i          (flush_i),
        .exmem_rd_i       (exmem_rd_i),
        .exmem_regwrite_i (exmem_regwrite_i),
        .exmem_result_i   (exmem_result_i),
        .memwb_rd_i       (memwb_rd_i),
        .memwb_regwrite_i (memwb_regwrite_i),
        .memwb_result_i   (memwb_result_i),
        .SrcA             (SrcA),
        .SrcB             (SrcB),
        .Operation        (Operation),
        .ex_valid_o       (ex_valid_o),
        .ex_regwrite_o    (ex_regwrite_o),
        .ex_memread_o     (ex_memread_o),
        .ex_memwrite_o    (ex_memwrite_o),
        .ex_branch_o      (ex_branch_o),
        .ex_rd_o          (ex_rd_o),
        .ex_pc_o          (ex_pc_o),
        .ex_store_data_o  (ex_store_data_o),
        .load_use_stall_o (load_use_stall_o)
`ifdef ID_EX_PERF_CNT_EN
        ,
        .bubble_cnt_o     (bubble_cnt_o),
        .stall_cnt_o      (stall_cnt_o)
`endif
    );

    typedef struct {
        logic        valid;
        logic [31:0] pc, rs1d, rs2d, imm;
        logic [4:0]  rs1, rs2, rd;
        logic        alusrc;
        logic [3:0]  op;
        logic        rw, mr, mw, br;
        logic [31:0] e_srca, e_srcb, e_store;
        logic        e_valid, e_rw, e_mr, e_mw, e_br;
        logic [4:0]  e_rd;
        logic [3:0]  e_op;
        logic        e_lus;
    } vec_t;

    typedef struct {
        logic [31:0] srca, srcb, store, pc;
        logic        valid, rw, mr, mw, br, lus;
        logic [4:0]  rd;
        logic [3:0]  op;
    } exp_t;

    vec_t vecs[8];
    exp_t sb_q[$];

    function automatic vec_t mk(
        input logic v, input logic [31:0] pc, rs1d, rs2d, imm,
        input logic [4:0] rs1, rs2, rd, input logic alusrc, input logic [3:0] op,
        input logic rw, mr, mw, br,
        input logic [31:0] es_a, es_b, es_st,
        input logic ev, erw, emr, emw, ebr, input logic [4:0] erd, input logic [3:0] eop,
        input logic elus);
        vec_t r;
        r.valid = v; r.pc = pc; r.rs1d = rs1d; r.rs2d = rs2d; r.imm = imm;
        r.rs1 = rs1; r.rs2 = rs2; r.rd = rd; r.alusrc = alusrc; r.op = op;
        r.rw = rw; r.mr = mr; r.mw = mw; r.br = br;
        r.e_srca = es_a; r.e_srcb = es_b; r.e_store = es_st;
        r.e_valid = ev; r.e_rw = erw; r.e_mr = emr; r.e_mw = emw; r.e_br = ebr;
        r.e_rd = erd; r.e_op = eop; r.e_lus = elus;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_id(input logic v, input logic [31:0] pc, rs1d, rs2d, imm,
                            input logic [4:0] rs1, rs2, rd, input logic alusrc,
                            input logic [3:0] op, input logic rw, mr, mw, br);
        id_valid_i = v; id_pc_i = pc; id_rs1_data_i = rs1d; id_rs2_data_i = rs2d;
        id_imm_i = imm; id_rs1_i = rs1; id_rs2_i = rs2; id_rd_i = rd;
        id_alusrc_i = alusrc; id_operation_i = op;
        id_regwrite_i = rw; id_memread_i = mr; id_memwrite_i = mw; id_branch_i = br;
    endtask

    task automatic clear_fwd();
        exmem_rd_i = '0; exmem_regwrite_i = 1'b0; exmem_result_i = '0;
        memwb_rd_i = '0; memwb_regwrite_i = 1'b0; memwb_result_i = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = mk(1, 32'h100, 32'd5, 32'd9, 32'd7, 5'd1, 5'd2, 5'd3, 1, ADD, 1, 0, 0, 0,
                     32'd5, 32'd7, 32'd9, 1, 1, 0, 0, 0, 5'd3, 4'd2, 0);
        vecs[1] = mk(1, 32'h104, 32'hFFFF_FFFF, 32'h8000_0000, 32'h10, 5'd7, 5'd8, 5'd9, 0, SUB, 1, 0, 0, 0,
                     32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000, 1, 1, 0, 0, 0, 5'd9, 4'd4, 0);
        vecs[2] = mk(0, 32'h108, 32'h11, 32'h22, 32'h33, 5'd1, 5'd2, 5'd5, 0, XOR, 1, 1, 1, 1,
                     32'h11, 32'h22, 32'h22, 0, 0, 0, 0, 0, 5'd5, 4'd3, 0);
        vecs[3] = mk(1, 32'h10C, 32'h40, 32'h0, 32'h4, 5'd10, 5'd11, 5'd12, 1, ADD, 1, 1, 0, 0,
                     32'h40, 32'h4, 32'h0, 1, 1, 1, 0, 0, 5'd12, 4'd2, 0);
        vecs[4] = mk(1, 32'h110, 32'h3, 32'h3, 32'hFFFF_FFF0, 5'd13, 5'd14, 5'd0, 0, EQ, 0, 0, 0, 1,
                     32'h3, 32'h3, 32'h3, 1, 0, 0, 0, 1, 5'd0, 4'd8, 0);
        vecs[5] = mk(1, 32'h114, 32'h1000, 32'hCAFE, 32'h8, 5'd15, 5'd16, 5'd0, 1, ADD, 0, 0, 1, 0,
                     32'h1000, 32'h8, 32'hCAFE, 1, 0, 0, 1, 0, 5'd0, 4'd2, 0);
        vecs[6] = mk(1, 32'h118, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 1, ADD, 1, 1, 0, 0,
                     32'h0, 32'h0, 32'h0, 1, 1, 1, 0, 0, 5'd0, 4'd2, 0);
        vecs[7] = mk(1, 32'h11C, 32'h77, 32'h88, 32'h99, 5'd0, 5'd20, 5'd21, 0, SRA, 1, 0, 0, 0,
                     32'h77, 32'h88, 32'h88, 1, 1, 0, 0, 0, 5'd21, 4'd9, 0);

        // Reset with a live-looking instruction on the ID inputs.
        stall_i = 0; flush_i = 0; clear_fwd();
        drive_id(1, 32'hDEAD, 32'h1, 32'h2, 32'h3, 5'd1, 5'd2, 5'd3, 1, SUB, 1, 1, 1, 1);
        rst_n = 0;
        step(); step();
        chk("rst_valid", {31'd0, ex_valid_o}, 32'd0);
        chk("rst_ctrl", {28'd0, ex_regwrite_o, ex_memread_o, ex_memwrite_o, ex_branch_o}, 32'd0);
        chk("rst_op", {28'd0, Operation}, 32'd0);
        chk("rst_rd", {27'd0, ex_rd_o}, 32'd0);
        chk("rst_pc", ex_pc_o, 32'd0);
        chk("rst_srca", SrcA, 32'd0);
        chk("rst_srcb", SrcB, 32'd0);
        chk("rst_store", ex_store_data_o, 32'd0);
        rst_n = 1;

        // Table of plain captures, scoreboarded.
        for (int i = 0; i < 8; i++) begin
            exp_t e;
            exp_t g;
            drive_id(vecs[i].valid, vecs[i].pc, vecs[i].rs1d, vecs[i].rs2d, vecs[i].imm,
                     vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].alusrc, vecs[i].op,
                     vecs[i].rw, vecs[i].mr, vecs[i].mw, vecs[i].br);
            e.srca = vecs[i].e_srca; e.srcb = vecs[i].e_srcb; e.store = vecs[i].e_store;
            e.pc = vecs[i].pc; e.valid = vecs[i].e_valid; e.rw = vecs[i].e_rw;
            e.mr = vecs[i].e_mr; e.mw = vecs[i].e_mw; e.br = vecs[i].e_br;
            e.lus = vecs[i].e_lus; e.rd = vecs[i].e_rd; e.op = vecs[i].e_op;
            sb_q.push_back(e);
            step();
            g = sb_q.pop_front();
            chk($sformatf("v%0d_srca", i), SrcA, g.srca);
            chk($sformatf("v%0d_srcb", i), SrcB, g.srcb);
            chk($sformatf("v%0d_store", i), ex_store_data_o, g.store);
            chk($sformatf("v%0d_pc", i), ex_pc_o, g.pc);
            chk($sformatf("v%0d_ctrl", i),
                {27'd0, ex_valid_o, ex_regwrite_o, ex_memread_o, ex_memwrite_o, ex_branch_o},
                {27'd0, g.valid, g.rw, g.mr, g.mw, g.br});
            chk($sformatf("v%0d_rd", i), {27'd0, ex_rd_o}, {27'd0, g.rd});
            chk($sformatf("v%0d_op", i), {28'd0, Operation}, {28'd0, g.op});
            chk($sformatf("v%0d_lus", i), {31'd0, load_use_stall_o}, {31'd0, g.lus});
        end

        // Forwarding priority on rs1, then on rs2.
        drive_id(1, 32'h200, 32'h55, 32'h66, 32'h0, 5'd3, 5'd7, 5'd8, 0, ADD, 1, 0, 0, 0);
        step();
        exmem_rd_i = 5'd3; exmem_regwrite_i = 1; exmem_result_i = 32'hAA;
        memwb_rd_i = 5'd3; memwb_regwrite_i = 1; memwb_result_i = 32'hBB;
        #1;
        chk("fwd_exmem", SrcA, 32'hAA);
        chk("fwd_exmem_srcb_untouched", SrcB, 32'h66);
        exmem_regwrite_i = 0;
        #1;
        chk("fwd_memwb", SrcA, 32'hBB);
        exmem_regwrite_i = 1; exmem_rd_i = 5'd0; memwb_rd_i = 5'd0;
        #1;
        chk("fwd_x0_none", SrcA, 32'h55);
        exmem_rd_i = 5'd7; exmem_result_i = 32'hCC;
        #1;
        chk("fwd_rs2_srcb", SrcB, 32'hCC);
        chk("fwd_rs2_store", ex_store_data_o, 32'hCC);
        clear_fwd();

        // Load-use: lw x4 in EX, consumer reads x4 as rs2.
        drive_id(1, 32'h300, 32'h1000, 32'h0, 32'h4, 5'd1, 5'd2, 5'd4, 1, ADD, 1, 1, 0, 0);
        step();
        drive_id(1, 32'h304, 32'h70, 32'h80, 32'h0, 5'd5, 5'd4, 5'd6, 0, ADD, 1, 0, 0, 0);
        #1;
        chk("lu_detect", {31'd0, load_use_stall_o}, 32'd1);
        flush_i = 1;
        #1;
        chk("lu_masked_by_flush", {31'd0, load_use_stall_o}, 32'd0);
        flush_i = 0;
        step();
        chk("lu_bubble_valid", {31'd0, ex_valid_o}, 32'd0);
        chk("lu_bubble_ctrl", {28'd0, ex_regwrite_o, ex_memread_o, ex_memwrite_o, ex_branch_o}, 32'd0);
        chk("lu_bubble_rd", {27'd0, ex_rd_o}, 32'd0);
        chk("lu_bubble_op", {28'd0, Operation}, 32'd0);
        chk("lu_bubble_srca", SrcA, 32'd0);
        chk("lu_release", {31'd0, load_use_stall_o}, 32'd0);
        step();
        chk("lu_capture_valid", {31'd0, ex_valid_o}, 32'd1);
        chk("lu_capture_rd", {27'd0, ex_rd_o}, 32'd6);
        chk("lu_capture_pc", ex_pc_o, 32'h304);
        chk("lu_capture_srca", SrcA, 32'h70);
        chk("lu_capture_srcb", SrcB, 32'h80);

        // Flush beats stall, then a 3-cycle hold.
        drive_id(1, 32'h400, 32'h1, 32'h2, 32'h3, 5'd1, 5'd2, 5'd9, 0, SUB, 1, 0, 0, 0);
        step();
        flush_i = 1; stall_i = 1;
        step();
        flush_i = 0; stall_i = 0;
        chk("fl_st_valid", {31'd0, ex_valid_o}, 32'd0);
        chk("fl_st_rw", {31'd0, ex_regwrite_o}, 32'd0);
        chk("fl_st_pc", ex_pc_o, 32'd0);
        drive_id(1, 32'h404, 32'h1111, 32'h2222, 32'h3333, 5'd17, 5'd18, 5'd19, 1, SLT, 1, 0, 0, 0);
        step();
        stall_i = 1;
        drive_id(1, 32'h408, 32'h5, 32'h6, 32'h7, 5'd1, 5'd2, 5'd3, 0, OR, 0, 1, 1, 1);
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("hold%0d_valid_rw", k), {30'd0, ex_valid_o, ex_regwrite_o}, 32'd3);
            chk($sformatf("hold%0d_other_ctrl", k), {29'd0, ex_memread_o, ex_memwrite_o, ex_branch_o}, 32'd0);
            chk($sformatf("hold%0d_pc", k), ex_pc_o, 32'h404);
            chk($sformatf("hold%0d_rd", k), {27'd0, ex_rd_o}, 32'd19);
            chk($sformatf("hold%0d_op", k), {28'd0, Operation}, 32'd5);
            chk($sformatf("hold%0d_srca", k), SrcA, 32'h1111);
            chk($sformatf("hold%0d_srcb", k), SrcB, 32'h3333);
            chk($sformatf("hold%0d_store", k), ex_store_data_o, 32'h2222);
        end
        stall_i = 0;

        // Store data forwarded while SrcB takes the immediate.
        exmem_rd_i = 5'd6; exmem_regwrite_i = 1; exmem_result_i = 32'h1234;
        drive_id(1, 32'h500, 32'h0, 32'h99, 32'h20, 5'd0, 5'd6, 5'd0, 1, ADD, 0, 0, 1, 0);
        step();
        chk("st_srcb_imm", SrcB, 32'h20);
        chk("st_store_fwd", ex_store_data_o, 32'h1234);
        chk("st_memwrite", {31'd0, ex_memwrite_o}, 32'd1);
        exmem_rd_i = 5'd0; exmem_result_i = 32'hDEAD;
        #1;
        chk("st_x0_srca", SrcA, 32'h0);
        clear_fwd();

`ifdef ID_EX_PERF_CNT_EN
        rst_n = 0;
        step();
        rst_n = 1;
        chk("cnt_rst_bubble", bubble_cnt_o, 32'd0);
        chk("cnt_rst_stall", stall_cnt_o, 32'd0);
        flush_i = 1;
        step(); step();
        flush_i = 0;
        drive_id(1, 32'h600, 32'h0, 32'h0, 32'h0, 5'd1, 5'd2, 5'd4, 1, ADD, 1, 1, 0, 0);
        step();
        drive_id(1, 32'h604, 32'h0, 32'h0, 32'h0, 5'd3, 5'd4, 5'd5, 0, ADD, 1, 0, 0, 0);
        step();
        stall_i = 1;
        step(); step(); step();
        stall_i = 0;
        chk("cnt_bubble", bubble_cnt_o, 32'd3);
        chk("cnt_stall", stall_cnt_o, 32'd3);
        rst_n = 0;
        step();
        rst_n = 1;
        chk("cnt_clr_bubble", bubble_cnt_o, 32'd0);
        chk("cnt_clr_stall", stall_cnt_o, 32'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register of the RISC-V core; sits directly upstream of the ALU.
- Captures decoded operands and control from ID and selects forwarded operands from EX/MEM and MEM/WB.
- Drives the ALU's SrcA, SrcB and Operation inputs.
- Detects load-use hazards and inserts bubbles itself.

Parameters:
- DATA_WIDTH, 32, operand/result width
- OPCODE_LENGTH, 4, ALU operation code width
- REG_ADDR_WIDTH, 5, register index width

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous active-low reset
- id_valid_i  in  1  ID holds a real instruction
- id_pc_i  in  DATA_WIDTH  instruction PC
- id_rs1_data_i / id_rs2_data_i  in  DATA_WIDTH  register file read data
- id_imm_i  in  DATA_WIDTH  sign-extended immediate
- id_rs1_i / id_rs2_i / id_rd_i  in  REG_ADDR_WIDTH  register indices
- id_alusrc_i  in  1  1 = SrcB from immediate
- id_operation_i  in  OPCODE_LENGTH  ALU operation
- id_regwrite_i / id_memread_i / id_memwrite_i / id_branch_i  in  1  control bits
- stall_i  in  1  downstream hold
- flush_i  in  1  taken branch/jump kill
- exmem_rd_i  in  REG_ADDR_WIDTH  EX/MEM destination
- exmem_regwrite_i  in  1  EX/MEM writes back
- exmem_result_i  in  DATA_WIDTH  EX/MEM ALU result
- memwb_rd_i  in  REG_ADDR_WIDTH  MEM/WB destination
- memwb_regwrite_i  in  1  MEM/WB writes back
- memwb_result_i  in  DATA_WIDTH  WB data
- SrcA / SrcB  out  DATA_WIDTH  ALU operands
- Operation  out  OPCODE_LENGTH  ALU operation
- ex_valid_o / ex_regwrite_o / ex_memread_o / ex_memwrite_o / ex_branch_o  out  1  registered control
- ex_rd_o  out  REG_ADDR_WIDTH  registered rd
- ex_pc_o  out  DATA_WIDTH  registered PC
- ex_store_data_o  out  DATA_WIDTH  forwarded rs2 value, for stores
- load_use_stall_o  out  1  tells IF/ID to hold PC and IF/ID register

Behaviour:
- Reset: all registered state is 0 when rst_n=0 at a clk edge. ex_valid_o=0, all control outputs 0, Operation=0, ex_rd_o=0, ex_pc_o=0. The combinational outputs SrcA, SrcB and ex_store_data_o therefore evaluate to 0, except when forwarding from a nonzero rd.
- Register update, priority per rising edge: rst_n=0 > flush_i > stall_i > load_use > normal load.
  - flush_i: load a bubble (valid=0, all control bits 0, operands 0). Flush wins over stall.
  - stall_i: hold every register unchanged.
  - load_use: load a bubble; the ID instruction is re-presented by the held IF/ID.
  - normal: capture all id_* inputs; valid = id_valid_i.
- Invalid capture: when id_valid_i=0, the regwrite/memread/memwrite/branch bits are forced to 0.
- load_use (combinational): ex_valid_o & ex_memread_o & ex_rd_o!=0 & id_valid_i & (id_rs1_i==ex_rd_o | id_rs2_i==ex_rd_o).
  - load_use_stall_o = load_use & ~flush_i.
  - While stall_i is high, load_use_stall_o can still be asserted. It is harmless, because upstream also holds on stall_i.
- Forwarding is combinational from the registered rs1/rs2 and the current EX/MEM and MEM/WB buses. For each source operand:
  - EX/MEM match (exmem_regwrite_i & exmem_rd_i!=0 & exmem_rd_i==rs) → exmem_result_i.
  - else MEM/WB match (same conditions) → memwb_result_i.
  - else the registered register-file value.
- Forwarding priority: EX/MEM over MEM/WB. x0 is never forwarded.
- Operand selection:
  - SrcA = forwarded rs1.
  - SrcB = id_alusrc registered ? registered imm : forwarded rs2.
  - ex_store_data_o = forwarded rs2, always.
- Latency: ID values appear on the outputs one cycle after capture. Operand paths are zero-latency from the forwarding buses.

Optional Feature:
- Macro ID_EX_PERF_CNT_EN.
- Defined:
  - Adds outputs bubble_cnt_o and stall_cnt_o, each 32 bits.
  - bubble_cnt_o increments on each edge where flush or load_use inserts a bubble.
  - stall_cnt_o increments on each stall_i hold.
  - Both reset to 0 and wrap at 2^32-1 → 0.
- Undefined: ports and logic are absent; core behaviour is identical.

Decomposition:
- Shared package core_pkg holds:
  - the DATA_WIDTH, OPCODE_LENGTH and REG_ADDR_WIDTH constants;
  - typedef alu_op_t for the 4-bit opcode, with named values AND=0, OR=1, ADD=2, XOR=3, SUB=4, SLT=5, SLL=6, SRL=7, EQ=8, SRA=9, BGE=10, BNE=12;
  - a packed struct ex_ctrl_t {regwrite, memread, memwrite, branch, alusrc}.
- One natural sub-module, fwd_mux: a single-operand forwarding select, instantiated twice (rs1 and rs2).

Test Plan:
1. Reset then a normal load: rst_n=0 for 2 cycles → all outputs 0. Then load rs1_data=5, imm=7, alusrc=1, op=ADD → next cycle SrcA=5, SrcB=7, Operation=2, ex_valid_o=1.
2. Forwarding priority: registered rs1=3; exmem rd=3/regwrite=1/result=0xAA; memwb rd=3/regwrite=1/result=0xBB → SrcA=0xAA. Drop exmem_regwrite_i → SrcA=0xBB. Set both rd=0 → SrcA=register value.
3. Load-use: EX holds lw with rd=4; ID has rs2=4 → load_use_stall_o=1; next edge ex_valid_o=0 with all control 0. The following cycle captures the instruction normally.
4. Flush versus stall: flush_i=1 and stall_i=1 on the same edge → bubble loaded. stall_i=1 alone for 3 cycles → outputs held bit-identical.
5. Store data: memwrite instruction with alusrc=1, rs2=6, exmem rd=6 result=0x1234 → SrcB=imm, ex_store_data_o=0x1234.
6. ID_EX_PERF_CNT_EN: 2 flushes, 1 load-use, 3 stall cycles → bubble_cnt_o=3, stall_cnt_o=3. Reset mid-count → both return to 0.
